// File: rtl/somador_seq_bcd.sv
// rtl/somador_seq_bcd.sv - sequential add/sub with double-dabble BCD and seven-segment output
module somador_seq_bcd #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter bit BLANK  = 1'b1
) (
   input  logic                  CLOCK_50,
   input  logic                  KEY0,
   input  logic [WIDTH-1:0]      A,
   input  logic [WIDTH-1:0]      B,
   input  logic                  Te,
   input  logic                  mode,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH:0]        S,
   output logic                  Ts,
   output logic [7*DIGITS-1:0]   HEX
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam int BW = 4 * DIGITS;
   // counter value seen on the edge that performs the final (WIDTH+1)th shift
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [WIDTH:0]  s_q, s_d;
   logic            ts_q, ts_d;
   logic [WIDTH:0]  shift_q, shift_d;
   logic [BW-1:0]   scratch_q, scratch_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [WIDTH:0]     res_w;
   logic [WIDTH:0]     mag_w;
   logic [BW-1:0]      adj_w;
   logic [BW+WIDTH:0]  cat_w;
   logic               accept_w;

   // seven-segment code, bit 6 = segment a, active-low
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b0000001;
         4'd1:    seg_of = 7'b1001111;
         4'd2:    seg_of = 7'b0010010;
         4'd3:    seg_of = 7'b0000110;
         4'd4:    seg_of = 7'b1001100;
         4'd5:    seg_of = 7'b0100100;
         4'd6:    seg_of = 7'b0100000;
         4'd7:    seg_of = 7'b0001111;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0000100;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   // state and datapath registers; reset aborts any operation in flight
   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         state_q   <= ST_IDLE;
         s_q       <= '0;
         ts_q      <= 1'b0;
         shift_q   <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         ts_q      <= ts_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
      end
   end

   // next-state: one CONV edge per result bit, then a single DONE cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_CONV;
         ST_CONV: if (cnt_q == LAST) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_DONE);
   end

   // arithmetic, magnitude and one double-dabble step
   always_comb begin
      logic [3:0] nib;
      nib = '0;
      if (mode)
         res_w = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Te};
      else
         res_w = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Te};
      // a negative difference is at least -2^WIDTH, so its negation still fits
      mag_w = (mode && res_w[WIDTH]) ? -res_w : res_w;
      adj_w = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         nib = scratch_q[4*i +: 4];
         adj_w[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
      cat_w = {adj_w, shift_q} << 1;
   end

   // register updates for capture and conversion
   always_comb begin
      accept_w  = (state_q == ST_IDLE) && start;
      s_d       = s_q;
      ts_d      = ts_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      if (accept_w) begin
         s_d       = res_w;
         // carry-out and sign-of-difference both land in the top bit
         ts_d      = res_w[WIDTH];
         shift_d   = mag_w;
         scratch_d = '0;
         cnt_d     = '0;
      end else if (state_q == ST_CONV) begin
         scratch_d = cat_w[BW+WIDTH:WIDTH+1];
         shift_d   = cat_w[WIDTH:0];
         cnt_d     = cnt_q + 1'b1;
         if (cnt_q == LAST) bcd_d = cat_w[BW+WIDTH:WIDTH+1];
      end
   end

   // display decode with leading-zero blanking from the top digit down
   always_comb begin
      logic       all_zero;
      logic [3:0] digit;
      HEX      = '1;
      all_zero = 1'b1;
      digit    = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         digit    = bcd_q[4*k +: 4];
         all_zero = all_zero && (digit == 4'd0);
         if (BLANK && (k != 0) && all_zero)
            HEX[7*k +: 7] = 7'b1111111;
         else
            HEX[7*k +: 7] = seg_of(digit);
      end
   end

   assign S  = s_q;
   assign Ts = ts_q;

endmodule

// File: tb/tb_somador_seq_bcd.sv
// tb/tb_somador_seq_bcd.sv - self-checking bench for somador_seq_bcd
module tb_somador_seq_bcd;

   localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100};

   logic clk = 1'b0;
   logic rst_n;
   logic [7:0] a8, b8;
   logic te8, md8, st8;
   logic busy8, done8, ts8;
   logic [8:0] s8;
   logic [20:0] hex8;
   logic busy_n, done_n, ts_n;
   logic [8:0] s_n;
   logic [20:0] hex_n;
   logic [3:0] a4, b4;
   logic te4, md4, st4;
   logic busy4, done4, ts4;
   logic [4:0] s4;
   logic [13:0] hex4;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   somador_seq_bcd #(.WIDTH(8), .DIGITS(3), .BLANK(1'b1)) dut (
      .CLOCK_50(clk), .KEY0(rst_n), .A(a8), .B(b8), .Te(te8), .mode(md8), .start(st8),
      .busy(busy8), .done(done8), .S(s8), .Ts(ts8), .HEX(hex8));

   somador_seq_bcd #(.WIDTH(8), .DIGITS(3), .BLANK(1'b0)) dut_nb (
      .CLOCK_50(clk), .KEY0(rst_n), .A(a8), .B(b8), .Te(te8), .mode(md8), .start(st8),
      .busy(busy_n), .done(done_n), .S(s_n), .Ts(ts_n), .HEX(hex_n));

   somador_seq_bcd #(.WIDTH(4), .DIGITS(2), .BLANK(1'b1)) dut4 (
      .CLOCK_50(clk), .KEY0(rst_n), .A(a4), .B(b4), .Te(te4), .mode(md4), .start(st4),
      .busy(busy4), .done(done4), .S(s4), .Ts(ts4), .HEX(hex4));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // digit k of the decimal value; digits above the value's length blank when requested
   function automatic logic [20:0] exp_hex(input int mag, input int nd, input bit blank);
      logic [20:0] h;
      int p;
      h = '1;
      p = 1;
      for (int k = 0; k < nd; k++) begin
         if (blank && k > 0 && mag < p) h[7*k +: 7] = 7'b1111111;
         else h[7*k +: 7] = SEG[(mag / p) % 10];
         p = p * 10;
      end
      return h;
   endfunction

   task automatic run_op(input bit sel4, input int a, input int b, input bit te, input bit md,
                         input string tag);
      int w, r, mask, mag, e;
      logic [20:0] eh;
      w = sel4 ? 4 : 8;
      r = md ? a - b - int'(te) : a + b + int'(te);
      mask = (1 << (w + 1)) - 1;
      mag = (r < 0) ? -r : r;
      @(negedge clk);
      if (sel4) begin
         a4 = 4'(a); b4 = 4'(b); te4 = te; md4 = md; st4 = 1'b1;
      end else begin
         a8 = 8'(a); b8 = 8'(b); te8 = te; md8 = md; st8 = 1'b1;
      end
      @(negedge clk);
      st4 = 1'b0; st8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); te8 = 1'($urandom); md8 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); te4 = 1'($urandom); md4 = 1'($urandom);
      check({tag, ":S"}, sel4 ? {27'b0, s4} : {23'b0, s8}, r & mask);
      check({tag, ":Ts"}, sel4 ? ts4 : ts8, md ? (r < 0) : (r >= (1 << w)));
      check({tag, ":busy"}, sel4 ? busy4 : busy8, 1);
      e = 31;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (sel4 ? done4 : done8) begin
            e = i;
            break;
         end
      end
      check({tag, ":latency"}, e, w + 1);
      eh = exp_hex(mag, sel4 ? 2 : 3, 1'b1);
      if (sel4) begin
         check({tag, ":HEX"}, {18'b0, hex4}, {18'b0, eh[13:0]});
      end else begin
         check({tag, ":HEX"}, {11'b0, hex8}, {11'b0, eh});
         check({tag, ":HEX_noblank"}, {11'b0, hex_n}, {11'b0, exp_hex(mag, 3, 1'b0)});
         check({tag, ":S_noblank"}, {23'b0, s_n}, r & mask);
      end
      @(negedge clk);
      check({tag, ":done_fall"}, sel4 ? done4 : done8, 0);
      check({tag, ":busy_fall"}, sel4 ? busy4 : busy8, 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      a8 = '0; b8 = '0; te8 = 1'b0; md8 = 1'b0; st8 = 1'b0;
      a4 = '0; b4 = '0; te4 = 1'b0; md4 = 1'b0; st4 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset:busy", busy8, 0);
      check("reset:done", done8, 0);
      check("reset:S", s8, 0);
      check("reset:Ts", ts8, 0);
      check("reset:HEX", hex8, exp_hex(0, 3, 1'b1));
      check("reset:HEX_noblank", hex_n, exp_hex(0, 3, 1'b0));
      check("reset:HEX4", hex4, 14'h3F81);
      rst_n = 1'b1;

      run_op(1'b0, 200, 100, 1'b1, 1'b0, "add_200_100_1");
      run_op(1'b0, 5, 9, 1'b0, 1'b1, "sub_5_9_0");
      run_op(1'b0, 255, 255, 1'b1, 1'b0, "add_max");
      run_op(1'b0, 0, 255, 1'b1, 1'b1, "sub_min");
      run_op(1'b0, 0, 0, 1'b0, 1'b0, "add_zero");
      run_op(1'b1, 9, 8, 1'b0, 1'b0, "w4_add_9_8");
      run_op(1'b1, 0, 15, 1'b1, 1'b1, "w4_sub_min");

      // start pulsed mid-conversion with other operands is ignored
      @(negedge clk);
      a8 = 100; b8 = 50; te8 = 1'b0; md8 = 1'b0; st8 = 1'b1;
      @(negedge clk);
      n = 0;
      for (int i = 0; i < 25; i++) begin
         if (i == 3) begin
            a8 = 7; b8 = 7; md8 = 1'b1; st8 = 1'b1;
         end else begin
            st8 = 1'b0;
         end
         @(negedge clk);
         if (done8) n++;
      end
      check("ignore:done_count", n, 1);
      check("ignore:S", s8, 150);
      check("ignore:HEX", hex8, exp_hex(150, 3, 1'b1));

      // start held high re-triggers
      @(negedge clk);
      a8 = 37; b8 = 90; te8 = 1'b0; md8 = 1'b0; st8 = 1'b1;
      n = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done8) n++;
      end
      st8 = 1'b0;
      check("b2b:pulses", n >= 2, 1);
      for (int i = 0; i < 30 && busy8; i++) @(negedge clk);
      check("b2b:idle", busy8, 0);
      check("b2b:S", s8, 127);
      check("b2b:HEX", hex8, exp_hex(127, 3, 1'b1));

      // reset asserted in the middle of a conversion
      @(negedge clk);
      a8 = 200; b8 = 55; te8 = 1'b0; md8 = 1'b0; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst:busy", busy8, 0);
      check("midrst:done", done8, 0);
      check("midrst:S", s8, 0);
      check("midrst:Ts", ts8, 0);
      check("midrst:HEX", hex8, exp_hex(0, 3, 1'b1));
      n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8) n++;
      end
      check("midrst:no_done", n, 0);
      run_op(1'b0, 123, 45, 1'b1, 1'b1, "after_reset");

      for (int i = 0; i < 16; i++)
         run_op(1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
                1'($urandom), 1'($urandom), $sformatf("rnd8_%0d", i));
      for (int i = 0; i < 6; i++)
         run_op(1'b1, $urandom_range(0, 15), $urandom_range(0, 15),
                1'($urandom), 1'($urandom), $sformatf("rnd4_%0d", i));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
